// File: rtl/ramb_tdp_param.sv
// ramb_tdp_param: single-clock true dual-port block RAM with byte write
// enables, per-port read-during-write mode, optional output register and
// same-address collision flags.
module ramb_tdp_param #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 8,
  parameter string                 WRITE_MODE_A = "WRITE_FIRST",
  parameter string                 WRITE_MODE_B = "WRITE_FIRST",
  parameter int                    DOA_REG      = 0,
  parameter int                    DOB_REG      = 0,
  parameter logic [DATA_WIDTH-1:0] SRVAL_A      = '0,
  parameter logic [DATA_WIDTH-1:0] SRVAL_B      = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDR_WIDTH-1:0]   ADDRA,
  input  logic [DATA_WIDTH-1:0]   DIA,
  input  logic [DATA_WIDTH/8-1:0] WEA,
  input  logic                    ENA,
  input  logic                    RSTA,
  output logic [DATA_WIDTH-1:0]   DOA,
  output logic                    COLLA,
  input  logic [ADDR_WIDTH-1:0]   ADDRB,
  input  logic [DATA_WIDTH-1:0]   DIB,
  input  logic [DATA_WIDTH/8-1:0] WEB,
  input  logic                    ENB,
  input  logic                    RSTB,
  output logic [DATA_WIDTH-1:0]   DOB,
  output logic                    COLLB
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Mode encoding: 0 write-first, 1 read-first, 2 no-change
  localparam int MODE_A = (WRITE_MODE_A == "READ_FIRST") ? 1 :
                          (WRITE_MODE_A == "NO_CHANGE")  ? 2 : 0;
  localparam int MODE_B = (WRITE_MODE_B == "READ_FIRST") ? 1 :
                          (WRITE_MODE_B == "NO_CHANGE")  ? 2 : 0;

  if (WRITE_MODE_A != "WRITE_FIRST" && WRITE_MODE_A != "READ_FIRST" &&
      WRITE_MODE_A != "NO_CHANGE") begin : g_bad_mode_a
    $error("ramb_tdp_param: illegal WRITE_MODE_A");
  end
  if (WRITE_MODE_B != "WRITE_FIRST" && WRITE_MODE_B != "READ_FIRST" &&
      WRITE_MODE_B != "NO_CHANGE") begin : g_bad_mode_b
    $error("ramb_tdp_param: illegal WRITE_MODE_B");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("ramb_tdp_param: DATA_WIDTH must be a multiple of 8");
  end

  // Written bytes come from the write data, the rest from the stored word
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] di,
    input logic [NB-1:0]         we
  );
    logic [DATA_WIDTH-1:0] res;
    res = old;
    for (int i = 0; i < NB; i++)
      if (we[i]) res[8*i +: 8] = di[8*i +: 8];
    return res;
  endfunction

  // Next value of a port's first output latch
  function automatic logic [DATA_WIDTH-1:0] stage1_next(
    input int                    mode,
    input logic                  en,
    input logic                  srst,
    input logic [NB-1:0]         we,
    input logic [DATA_WIDTH-1:0] di,
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] prev,
    input logic [DATA_WIDTH-1:0] srval
  );
    logic [DATA_WIDTH-1:0] res;
    res = prev;
    if (en) begin
      if (srst)          res = srval;
      else if (we == '0) res = old;
      else if (mode == 0) res = byte_merge(old, di, we);
      else if (mode == 1) res = old;
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  logic [DATA_WIDTH-1:0] old_a, old_b, nxt_a, nxt_b;
  logic                  coll;
  logic [DATA_WIDTH-1:0] doa_p1, dob_p1, doa_p2, dob_p2;
  logic                  vld_a_p1, vld_b_p1, colla_p1, collb_p1;

  // Read the stored words and decide the stage-1 updates
  always_comb begin
    old_a = mem[ADDRA];
    old_b = mem[ADDRB];
    coll  = ENA && ENB && (ADDRA == ADDRB) && ((|WEA) || (|WEB));
    nxt_a = stage1_next(MODE_A, ENA, RSTA, WEA, DIA, old_a, doa_p1, SRVAL_A);
    nxt_b = stage1_next(MODE_B, ENB, RSTB, WEB, DIB, old_b, dob_p1, SRVAL_B);
  end

  // Array writes; port A is issued last so it wins any shared byte
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (ENB && WEB[i]) mem[ADDRB][8*i +: 8] <= DIB[8*i +: 8];
      if (ENA && WEA[i]) mem[ADDRA][8*i +: 8] <= DIA[8*i +: 8];
    end
  end

  // Stage 1 (output latch, collision flags) and stage 2 (optional register)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      doa_p1   <= SRVAL_A;
      dob_p1   <= SRVAL_B;
      doa_p2   <= SRVAL_A;
      dob_p2   <= SRVAL_B;
      vld_a_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
      colla_p1 <= 1'b0;
      collb_p1 <= 1'b0;
    end else begin
      // p1: latch read data and collision status
      doa_p1   <= nxt_a;
      dob_p1   <= nxt_b;
      vld_a_p1 <= ENA;
      vld_b_p1 <= ENB;
      colla_p1 <= coll;
      collb_p1 <= coll;
      // p2: follow stage 1 only when an access is in flight
      if (vld_a_p1) doa_p2 <= RSTA ? SRVAL_A : doa_p1;
      if (vld_b_p1) dob_p2 <= RSTB ? SRVAL_B : dob_p1;
    end
  end

  assign DOA   = (DOA_REG != 0) ? doa_p2 : doa_p1;
  assign DOB   = (DOB_REG != 0) ? dob_p2 : dob_p1;
  assign COLLA = colla_p1;
  assign COLLB = collb_p1;

endmodule

// File: tb/tb_ramb_tdp_param.sv
// tb_ramb_tdp_param: three RAM instances with different write modes and
// output registers share one stimulus and are checked against a word-level
// reference model.
module tb_ramb_tdp_param;

  localparam logic [15:0] SRA = 16'h5A5A;
  localparam logic [15:0] SRB = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena, enb, rsta, rstb;
  logic [7:0]  addra, addrb;
  logic [15:0] dia, dib;
  logic [1:0]  wea, web;

  logic [15:0] doa0, doa1, doa2, dob0, dob1, dob2;
  logic        colla0, colla1, colla2, collb0, collb1, collb2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // inst 0: A write-first, B read-first + output reg
  ramb_tdp_param #(.WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"),
    .DOA_REG(0), .DOB_REG(1), .SRVAL_A(SRA), .SRVAL_B(SRB)) u_wf (
    .CLK(clk), .RST(rst),
    .ADDRA(addra), .DIA(dia), .WEA(wea), .ENA(ena), .RSTA(rsta), .DOA(doa0), .COLLA(colla0),
    .ADDRB(addrb), .DIB(dib), .WEB(web), .ENB(enb), .RSTB(rstb), .DOB(dob0), .COLLB(collb0));

  // inst 1: A read-first, B no-change
  ramb_tdp_param #(.WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
    .DOA_REG(0), .DOB_REG(0), .SRVAL_A(SRA), .SRVAL_B(SRB)) u_rf (
    .CLK(clk), .RST(rst),
    .ADDRA(addra), .DIA(dia), .WEA(wea), .ENA(ena), .RSTA(rsta), .DOA(doa1), .COLLA(colla1),
    .ADDRB(addrb), .DIB(dib), .WEB(web), .ENB(enb), .RSTB(rstb), .DOB(dob1), .COLLB(collb1));

  // inst 2: A no-change + output reg, B write-first
  ramb_tdp_param #(.WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("WRITE_FIRST"),
    .DOA_REG(1), .DOB_REG(0), .SRVAL_A(SRA), .SRVAL_B(SRB)) u_nc (
    .CLK(clk), .RST(rst),
    .ADDRA(addra), .DIA(dia), .WEA(wea), .ENA(ena), .RSTA(rsta), .DOA(doa2), .COLLA(colla2),
    .ADDRB(addrb), .DIB(dib), .WEB(web), .ENB(enb), .RSTB(rstb), .DOB(dob2), .COLLB(collb2));

  // Reference model: mode 0 write-first, 1 read-first, 2 no-change
  int          modes [3][2] = '{'{0, 1}, '{1, 2}, '{2, 0}};
  int          regs  [3][2] = '{'{0, 1}, '{0, 0}, '{1, 0}};
  logic [15:0] mmem [256];
  logic [15:0] s1 [3][2];
  logic [15:0] s2 [3][2];
  logic        mv [3][2];
  logic        mcoll;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] get_do(input int i, input int p);
    case (i * 2 + p)
      0: return doa0;
      1: return dob0;
      2: return doa1;
      3: return dob1;
      4: return doa2;
      default: return dob2;
    endcase
  endfunction

  function automatic logic [15:0] get_coll(input int i, input int p);
    case (i * 2 + p)
      0: return {15'd0, colla0};
      1: return {15'd0, collb0};
      2: return {15'd0, colla1};
      3: return {15'd0, collb1};
      4: return {15'd0, colla2};
      default: return {15'd0, collb2};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      s1[i][0] = SRA; s2[i][0] = SRA;
      s1[i][1] = SRB; s2[i][1] = SRB;
      mv[i][0] = 1'b0; mv[i][1] = 1'b0;
    end
    mcoll = 1'b0;
  endtask

  // Apply one clock edge worth of spec rules to the model, using current inputs
  task automatic model_edge();
    logic        en [2];
    logic        rs [2];
    logic [1:0]  we [2];
    logic [15:0] di [2];
    logic [15:0] old [2];
    logic [15:0] sv [2];
    logic [15:0] nw;
    en[0] = ena; en[1] = enb; rs[0] = rsta; rs[1] = rstb;
    we[0] = wea; we[1] = web; di[0] = dia; di[1] = dib;
    old[0] = mmem[addra]; old[1] = mmem[addrb];
    sv[0] = SRA; sv[1] = SRB;
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (mv[i][p]) s2[i][p] = rs[p] ? sv[p] : s1[i][p];
        mv[i][p] = en[p];
        if (en[p]) begin
          if (rs[p]) s1[i][p] = sv[p];
          else if (we[p] == 2'b00) s1[i][p] = old[p];
          else if (modes[i][p] == 0) begin
            nw = old[p];
            if (we[p][0]) nw[7:0]  = di[p][7:0];
            if (we[p][1]) nw[15:8] = di[p][15:8];
            s1[i][p] = nw;
          end else if (modes[i][p] == 1) s1[i][p] = old[p];
        end
      end
    end
    mcoll = ena && enb && (addra == addrb) && ((wea != 2'b00) || (web != 2'b00));
    // Port B bytes land only where port A does not write the same byte
    for (int k = 0; k < 2; k++) begin
      if (enb && web[k] && !(ena && wea[k] && addra == addrb))
        mmem[addrb][8*k +: 8] = dib[8*k +: 8];
      if (ena && wea[k])
        mmem[addra][8*k +: 8] = dia[8*k +: 8];
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("%s_do%0d%s", tag, i, p ? "b" : "a"), get_do(i, p),
            regs[i][p] ? s2[i][p] : s1[i][p]);
        chk($sformatf("%s_coll%0d%s", tag, i, p ? "b" : "a"), get_coll(i, p),
            {15'd0, mcoll});
      end
    end
  endtask

  task automatic idle();
    ena = 0; enb = 0; rsta = 0; rstb = 0;
    wea = 2'b00; web = 2'b00;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mmem[a] = 16'h0000;
    idle();
    addra = 0; addrb = 0; dia = 0; dib = 0;
    #1 rst = 1'b1;
    model_reset();
    #2 check_all("rst");
    @(posedge clk); #1 check_all("rst_hold");
    @(negedge clk) rst = 1'b0;

    // Write then cross-port read
    ena = 1; addra = 8'h10; dia = 16'hBEEF; wea = 2'b11; step("t1w");
    chk("t1_doa_wf", doa0, 16'hBEEF);
    idle(); enb = 1; addrb = 8'h10; step("t1r");
    chk("t1_dob_nc", dob1, 16'hBEEF);
    idle(); step("t1i");
    chk("t1_dob_reg", dob0, 16'hBEEF);

    // Byte enables
    ena = 1; addra = 8'h05; dia = 16'h1234; wea = 2'b11; step("t2a");
    dia = 16'hABCD; wea = 2'b01; step("t2b");
    wea = 2'b00; step("t2r");
    chk("t2_merge", doa0, 16'h12CD);

    // Read-during-write modes on port A
    idle(); ena = 1; addra = 8'h20; dia = 16'h0F0F; wea = 2'b11; step("t3a");
    wea = 2'b00; step("t3b");
    addra = 8'h21; dia = 16'h1111; wea = 2'b11; step("t3c");
    dia = 16'h5555; step("t3d");
    chk("t3_wf", doa0, 16'h5555);
    chk("t3_rf", doa1, 16'h1111);
    idle(); step("t3e");
    chk("t3_nc", doa2, 16'h0F0F);

    // Collisions
    ena = 1; enb = 1; addra = 8'h07; addrb = 8'h07;
    dia = 16'hAAAA; wea = 2'b11; dib = 16'hBBBB; web = 2'b10; step("t4a");
    chk("t4_colla", {15'd0, colla0}, 16'd1);
    chk("t4_collb", {15'd0, collb2}, 16'd1);
    idle(); step("t4b");
    chk("t4_colla_clr", {15'd0, colla0}, 16'd0);
    ena = 1; addra = 8'h07; step("t4c");
    chk("t4_mem1", doa1, 16'hAAAA);
    enb = 1; addrb = 8'h07; wea = 2'b01; web = 2'b10; step("t4d");
    chk("t4_collb2", {15'd0, collb1}, 16'd1);
    idle(); ena = 1; step("t4e");
    chk("t4_mem2", doa1, 16'hBBAA);

    // Port B output register latency and sync reset
    idle(); ena = 1; addra = 8'h03; dia = 16'h0042; wea = 2'b11; step("t5a");
    idle(); enb = 1; addrb = 8'h03; step("t5b");
    idle(); step("t5c");
    chk("t5_dob_lat2", dob0, 16'h0042);
    enb = 1; rstb = 1; step("t5d");
    idle(); step("t5e");
    chk("t5_dob_srval", dob0, SRB);

    // Asynchronous reset with values in flight
    enb = 1; addrb = 8'h03; ena = 1; addra = 8'h07; step("t6a");
    idle();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("t6rst");
    chk("t6_doa", doa0, SRA);
    chk("t6_dob", dob0, SRB);
    #1 rst = 1'b0;
    ena = 1; addra = 8'h10; step("t6r");
    chk("t6_mem", doa0, 16'hBEEF);

    // Randomised traffic on a small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      ena   = 1'($urandom_range(0, 1));
      enb   = 1'($urandom_range(0, 1));
      rsta  = ($urandom_range(0, 7) == 0);
      rstb  = ($urandom_range(0, 7) == 0);
      addra = 8'($urandom_range(0, 7));
      addrb = 8'($urandom_range(0, 7));
      dia   = 16'($urandom);
      dib   = 16'($urandom);
      wea   = 2'($urandom_range(0, 3));
      web   = 2'($urandom_range(0, 3));
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ramb_tdp_param.md
Name: ramb_tdp_param

Overview:
Parametrised single-clock true dual-port block RAM. It generalises the fixed 256x16 dual-port primitive with configurable depth and width, per-byte write enables, a per-port write mode, an optional output pipeline register and same-address collision flags. It is the RAM leaf under FIFOs, line buffers and the RAMB4-style wrappers in the unisim library.

Parameters:
DATA_WIDTH, 16, word width; a multiple of 8.
ADDR_WIDTH, 8, address width; depth is 2**ADDR_WIDTH.
WRITE_MODE_A, "WRITE_FIRST", port A read-during-write mode: "WRITE_FIRST", "READ_FIRST" or "NO_CHANGE".
WRITE_MODE_B, "WRITE_FIRST", same as WRITE_MODE_A, for port B.
DOA_REG, 0, 1 adds an output pipeline register on port A.
DOB_REG, 0, same as DOA_REG, for port B.
SRVAL_A, 0, DATA_WIDTH-bit value loaded into the port A output by reset.
SRVAL_B, 0, same as SRVAL_A, for port B.
INIT_VALUE, 0, DATA_WIDTH-bit power-up value of every word.

Ports:
CLK  input  1  single clock for both ports; rising edge.
RST  input  1  asynchronous active-high reset of output and control state. Memory contents are not affected.
ADDRA  input  ADDR_WIDTH  port A address.
DIA  input  DATA_WIDTH  port A write data.
WEA  input  DATA_WIDTH/8  port A byte write enables; bit i covers DIA[8i+7:8i].
ENA  input  1  port A enable.
RSTA  input  1  port A synchronous output set/reset.
DOA  output  DATA_WIDTH  port A read data.
COLLA  output  1  registered flag: collision involving port A this access.
ADDRB, DIB, WEB, ENB, RSTB, DOB, COLLB: port B equivalents, same widths.

Behaviour:
- RST asserted, asynchronously:
  - DOA=SRVAL_A, DOB=SRVAL_B (both pipeline stages), COLLA=COLLB=0, internal valid bits=0.
  - RAM array retains its contents.
  - Deassertion is synchronised by the user; the block has no internal reset synchroniser.
- Per port x, per rising edge with ENx=1:
  - Every byte i with WEx[i]=1 is written.
  - Stage-1 output latch:
    - RSTx=1 -> SRVALx. The write still occurs.
    - Else WEx==0 -> mem[ADDRx] (old contents).
    - Else WRITE_FIRST -> merged new word (written bytes from DIx, others from memory).
    - Else READ_FIRST -> old word.
    - Else NO_CHANGE -> latch holds its previous value.
- ENx=0: no write; stage-1 latch holds; RSTx is ignored.
- Latency:
  - DOx_REG=0: DOx = stage-1 latch, valid 1 cycle after the enable edge.
  - DOx_REG=1: stage-2 register loads stage-1 on the edge after each enabled access (tracked by a valid bit), so latency is 2.
  - With DOx_REG=1, stage 2 loads SRVALx if RSTx=1 on that edge.
  - Stage 2 holds when no access is in flight.
- Collision, evaluated each edge: ENA=ENB=1 and ADDRA==ADDRB and (|WEA or |WEB).
  - COLLA and COLLB are set to 1 for one cycle, aligned with stage 1. They do not pass through the DOx_REG pipeline.
  - Both ports write: for each byte, port A wins wherever WEA[i]=1; port B's byte is written only where WEA[i]=0. No X is ever written.
  - One port writes, the other reads: the reader gets the old word (READ_FIRST across ports) regardless of its own WRITE_MODE. The writer follows its own mode.
  - Both ports only read: no collision.
- Address wrap: none; every ADDR value is a legal, distinct word.
- Reset mid-operation: an in-flight pipeline value is discarded (the valid bit is cleared). A write captured on the same edge that RST asserts is not guaranteed.
- Elaboration check: an illegal WRITE_MODE or a DATA_WIDTH not divisible by 8 raises $error.

Test Plan:
1. WRITE_FIRST, DOA_REG=0, DATA_WIDTH=16: write 0xBEEF at A addr 0x10, WEA=2'b11 -> DOA=0xBEEF next cycle; B reads 0x10 one cycle later -> DOB=0xBEEF.
2. Byte enables: word 0x1234 at addr 5, A writes 0xABCD with WEA=2'b01 -> memory word 0x12CD.
3. Per-mode read-during-write on port A, writing 0x5555 over 0x1111:
   - READ_FIRST -> DOA=0x1111.
   - WRITE_FIRST -> DOA=0x5555.
   - NO_CHANGE -> DOA keeps its prior value, 0x0F0F.
4. Collision, addr 7: A writes 0xAAAA with WEA=2'b11, B writes 0xBBBB with WEB=2'b10 -> memory 0xAAAA, COLLA=COLLB=1 for exactly 1 cycle. Repeat with WEA=2'b01 -> memory 0xBBAA.
5. DOB_REG=1: B reads addr 3 holding 0x0042 -> DOB changes 2 cycles after the edge; RSTB=1 with ENB=1 -> DOB=SRVAL_B after 2 cycles.
6. RST asserted mid-cycle with a stage-2 value pending -> DOA=SRVAL_A and DOB=SRVAL_B immediately; memory is unchanged afterwards (re-read 0xBEEF at 0x10).
